// File: rtl/golomb_encode_pack.sv
// Rice/Golomb encoder with an MSB-first 32-bit word packer.
// Optional macro GOLOMB_ESCAPE_EN: symbols with q >= 23 get a 40-bit escape
// code (24 zeros + raw value). Without it they are dropped and set overflow.
module golomb_encode_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_value,
  input  logic [3:0]  in_k,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        flush_done,
  output logic        overflow
);

  localparam int unsigned ACC_W  = 72;
  localparam int unsigned FILL_W = 7;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned VAL_W  = 16;
  localparam int unsigned CODE_W = 40;
  localparam int unsigned Q_MAX  = 22;

  typedef enum logic [1:0] {RUN, FLUSH, LAST} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               done_d;
  logic [VAL_W-1:0]   q, r;
  logic               is_esc;
  logic [CODE_W-1:0]  code_val;
  logic [FILL_W-1:0]  code_len;
  logic [FILL_W-1:0]  sh;
  logic               accept, take;
`ifndef GOLOMB_ESCAPE_EN
  logic               ovf_d;
`endif

  // Split the residual into quotient/remainder and form the right-aligned code.
  always_comb begin
    q        = in_value >> in_k;
    r        = in_value & ((VAL_W'(1) << in_k) - VAL_W'(1));
    is_esc   = q > VAL_W'(Q_MAX);
    code_val = '0;
    code_len = '0;
    if (!is_esc) begin
      code_val = (CODE_W'(1) << in_k) | CODE_W'(r);
      code_len = FILL_W'(q) + FILL_W'(in_k) + FILL_W'(1);
    end else begin
`ifdef GOLOMB_ESCAPE_EN
      code_val = CODE_W'(in_value);
      code_len = FILL_W'(CODE_W);
`endif
    end
    sh = FILL_W'(ACC_W) - fill_q - code_len;
  end

  // Next-state, accumulator update and handshake outputs.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    fill_d    = fill_q;
    done_d    = 1'b0;
`ifndef GOLOMB_ESCAPE_EN
    ovf_d     = overflow;
`endif
    in_ready  = (fill_q < FILL_W'(WORD_W)) && (state_q == RUN);
    out_valid = (state_q == LAST) || (fill_q >= FILL_W'(WORD_W));
    out_last  = (state_q == LAST);
    out_data  = acc_q[ACC_W-1 -: WORD_W];
    accept    = in_valid && in_ready;
    take      = out_valid && out_ready;
    case (state_q)
      RUN: begin
        if (accept) begin
          acc_d  = acc_q | (ACC_W'(code_val) << sh);
          fill_d = fill_q + code_len;
`ifndef GOLOMB_ESCAPE_EN
          if (is_esc) ovf_d = 1'b1;
`endif
        end
        if (take) begin
          acc_d  = acc_q << WORD_W;
          fill_d = fill_q - FILL_W'(WORD_W);
        end
        if (flush) state_d = FLUSH;
      end
      FLUSH: begin
        if (fill_q >= FILL_W'(WORD_W)) begin
          if (take) begin
            acc_d  = acc_q << WORD_W;
            fill_d = fill_q - FILL_W'(WORD_W);
          end
        end else if (fill_q == '0) begin
          done_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = LAST;
        end
      end
      LAST: begin
        if (take) begin
          acc_d   = '0;
          fill_d  = '0;
          done_d  = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Accumulator, fill count and flush completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      fill_q     <= '0;
      flush_done <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      flush_done <= done_d;
    end
  end

`ifdef GOLOMB_ESCAPE_EN
  assign overflow = 1'b0;
`else
  // Sticky overflow, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else     overflow <= ovf_d;
  end
`endif

endmodule

// File: tb/tb_golomb_encode_pack.sv
// Directed bench for golomb_encode_pack; covers escape or overflow per GOLOMB_ESCAPE_EN.
module tb_golomb_encode_pack;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic        out_last, flush_done, overflow;
  logic [15:0] in_value;
  logic [3:0]  in_k;
  logic [31:0] out_data;
  int          n_vec = 0;
  int          n_err = 0;

  golomb_encode_pack dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .in_k(in_k), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .flush_done(flush_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] v, input logic [3:0] k);
    in_valid = 1'b1; in_value = v; in_k = k;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_value = '0; in_k = '0; flush = 1'b0; out_ready = 1'b0;
    step(); step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_flush_done", 32'(flush_done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    step();

    // 8 x (5,k=1) -> "0011" x 8 = 0x33333333
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(16'd5, 4'd1);
      if (i < 7) begin
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        check("b2b_no_valid", 32'(out_valid), 32'd0);
      end
    end
    check("b2b_valid", 32'(out_valid), 32'd1);
    check("b2b_data", out_data, 32'h3333_3333);
    check("b2b_last", 32'(out_last), 32'd0);
    check("b2b_in_ready_full", 32'(in_ready), 32'd0);
    step();
    check("b2b_drained", 32'(out_valid), 32'd0);
    check("b2b_ready_again", 32'(in_ready), 32'd1);

    // Backpressure: word held 10 cycles, next symbol (3,k=1)="011" waits
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(16'd5, 4'd1);
    in_valid = 1'b1; in_value = 16'd3; in_k = 4'd1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", out_data, 32'h3333_3333);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_in_ready", 32'(in_ready), 32'd0);
    check("fl_valid", 32'(out_valid), 32'd0);
    step();
    check("last_valid", 32'(out_valid), 32'd1);
    check("last_last", 32'(out_last), 32'd1);
    check("last_data", out_data, 32'h6000_0000);
    check("last_no_done", 32'(flush_done), 32'd0);
    step();
    check("last_done", 32'(flush_done), 32'd1);
    check("last_gone", 32'(out_valid), 32'd0);
    check("last_gone_last", 32'(out_last), 32'd0);
    check("last_ready", 32'(in_ready), 32'd1);
    step();
    check("last_done_pulse", 32'(flush_done), 32'd0);

    // Flush with empty accumulator
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("ef_valid0", 32'(out_valid), 32'd0);
    check("ef_done0", 32'(flush_done), 32'd0);
    step();
    check("ef_valid1", 32'(out_valid), 32'd0);
    check("ef_done1", 32'(flush_done), 32'd1);
    step();
    check("ef_done2", 32'(flush_done), 32'd0);

`ifdef GOLOMB_ESCAPE_EN
    // value=100,k=0 -> 24 zeros + 0x0064
    send(16'd100, 4'd0);
    check("esc_valid", 32'(out_valid), 32'd1);
    check("esc_data0", out_data, 32'h0000_0000);
    check("esc_last0", 32'(out_last), 32'd0);
    check("esc_overflow", 32'(overflow), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("esc_fl_valid", 32'(out_valid), 32'd0);
    step();
    check("esc_last_valid", 32'(out_valid), 32'd1);
    check("esc_last", 32'(out_last), 32'd1);
    check("esc_data1", out_data, 32'h6400_0000);
    step();
    check("esc_done", 32'(flush_done), 32'd1);
    check("esc_gone", 32'(out_valid), 32'd0);
`else
    // value=100,k=0 dropped mid-word: overflow set, fill untouched
    for (int i = 0; i < 4; i++) send(16'd5, 4'd1);
    check("ovf_pre", 32'(overflow), 32'd0);
    check("ovf_ready", 32'(in_ready), 32'd1);
    send(16'd100, 4'd0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_no_word", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) send(16'd5, 4'd1);
    check("ovf_fill_kept", 32'(out_valid), 32'd0);
    send(16'd5, 4'd1);
    check("ovf_word_valid", 32'(out_valid), 32'd1);
    check("ovf_word_data", out_data, 32'h3333_3333);
    step();
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_drained", 32'(out_valid), 32'd0);
`endif

    // (0xFFFF,k=15): "01"+15 ones; (22,k=0): 22 zeros + "1" (longest non-escape q)
    send(16'hFFFF, 4'd15);
    check("long_no_word", 32'(out_valid), 32'd0);
    send(16'd22, 4'd0);
    check("long_valid", 32'(out_valid), 32'd1);
    check("long_data", out_data, 32'h7FFF_8000);
    flush = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b0;
    check("long_fl_valid", 32'(out_valid), 32'd0);
    step();
    check("long_last_data", out_data, 32'h0100_0000);
    check("long_last", 32'(out_last), 32'd1);
    step();
    check("long_stall_data", out_data, 32'h0100_0000);
    check("long_stall_valid", 32'(out_valid), 32'd1);

    // Reset while stalled in LAST
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rl_valid", 32'(out_valid), 32'd0);
    check("rl_last", 32'(out_last), 32'd0);
    check("rl_in_ready", 32'(in_ready), 32'd1);
    check("rl_done", 32'(flush_done), 32'd0);
    check("rl_overflow", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send(16'd5, 4'd1);
    check("rl_fill0", 32'(out_valid), 32'd0);
    send(16'd5, 4'd1);
    check("rl_word_valid", 32'(out_valid), 32'd1);
    check("rl_word_data", out_data, 32'h3333_3333);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/golomb_encode_pack.md
GOLOMB_ENCODE_PACK -- requirements
Module: golomb_encode_pack

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: in_valid  in  1  symbol offered.
REQ-004 SHALL have ports: in_ready  out  1  symbol accepted when in_valid && in_ready at clk edge.
REQ-005 SHALL have ports: in_value  in  16  unsigned residual to encode.
REQ-006 SHALL have ports: in_k  in  4  Rice parameter k, 0..15.
REQ-007 SHALL have ports: flush  in  1  single-cycle request to drain and zero-pad the final word.
REQ-008 SHALL have ports: out_valid  out  1  packed word available.
REQ-009 SHALL have ports: out_ready  in  1  consumer takes the word when out_valid && out_ready.
REQ-010 SHALL have ports: out_data  out  32  packed bitstream word, first coded bit at bit 31.
REQ-011 SHALL have ports: out_last  out  1  marks the final, zero-padded word of a flush.
REQ-012 SHALL have ports: flush_done  out  1  one-cycle pulse when the flush completes.
REQ-013 SHALL have ports: overflow  out  1  sticky error flag, present only without GOLOMB_ESCAPE_EN.

Function
REQ-014 SHALL compute q = in_value >> in_k and r = in_value mod 2^in_k.
REQ-015 SHALL encode q <= 22 as q '0' bits, then one '1', then r in k bits, MSB first; length q+1+k, maximum 38.
REQ-016 SHALL encode q >= 23 (escape) as 24 '0' bits followed by in_value in 16 bits, MSB first; length 40.
REQ-017 SHALL pack codes MSB-first into a 72-bit accumulator with a 7-bit fill count.
REQ-018 SHALL append each accepted symbol's code directly below the existing fill at the next clk edge; one symbol per cycle maximum.
REQ-019 SHALL drive in_ready = (fill < 32) && state == RUN.
REQ-020 SHALL drive out_valid = (fill >= 32) in RUN, with out_data = accumulator bits [71:40].
REQ-021 SHALL, on an out handshake, shift the accumulator left 32 and reduce fill by 32; a second word follows at once if fill is still >= 32.
REQ-022 SHALL hold out_data, out_valid and out_last stable while out_valid && !out_ready.
REQ-023 SHALL use states RUN, FLUSH and LAST.
REQ-024 SHALL, on flush in RUN, enter FLUSH; flush in any other state SHALL be ignored.
REQ-025 SHALL, in FLUSH, emit full words as in RUN.
REQ-026 SHALL, in FLUSH, go to LAST when 0 < fill < 32.
REQ-027 SHALL, in FLUSH with fill == 0, pulse flush_done and return to RUN.
REQ-028 SHALL, in LAST, present the residual bits zero-padded with out_valid=1 and out_last=1.
REQ-029 SHALL, on the LAST handshake, clear the accumulator, set fill=0, pulse flush_done and return to RUN.
REQ-030 SHALL, if flush and in_valid coincide in RUN with in_ready=1, accept the symbol and include it in the flush.

Reset
REQ-031 SHALL, on rst, clear the accumulator, set fill=0 and state RUN, and drive outputs to 0 except in_ready=1, irrespective of flush or handshake activity.

Configuration
REQ-032 SHALL, with GOLOMB_ESCAPE_EN defined, implement the escape code of REQ-016, tie overflow to 0 and leave it unused.
REQ-033 SHALL, without GOLOMB_ESCAPE_EN, omit escape logic; a symbol with q >= 23 is accepted, appends no bits and sets overflow.
REQ-034 SHALL clear overflow only by rst.

Verification
REQ-035 SHALL cover: 8 symbols value=5,k=1 back-to-back, out_ready=1 -> single word 0x33333333 with out_valid the cycle after the 8th acceptance, out_last=0.
REQ-036 SHALL cover, with GOLOMB_ESCAPE_EN: value=100,k=0 then flush -> words 0x00000000, then 0x64000000 with out_last=1, then a flush_done pulse.
REQ-037 SHALL cover: out_ready held low 10 cycles with one word pending -> out_data stable, in_ready=0 once fill >= 32, no bits lost after release.
REQ-038 SHALL cover: flush with fill=0 -> no out_valid, flush_done one cycle later.
REQ-039 SHALL cover, without GOLOMB_ESCAPE_EN: value=100,k=0 -> overflow=1 sticky, fill unchanged.
REQ-040 SHALL cover: rst asserted in LAST with out_ready=0 -> next cycle out_valid=0, out_last=0, in_ready=1, fill=0.
